// File: rtl/alu_word_sequencer.sv
// Runs a 16-bit ALU op as two passes through an external 8-bit combinational ALU.
// Optional byte-only ops (single low-byte pass) are enabled by ALU_SEQ_BYTE_MODE_EN.
module alu_word_sequencer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [15:0] req_a_i,
    input  logic [15:0] req_b_i,
    input  logic [3:0]  req_s_i,
    input  logic        req_m_i,
    input  logic        req_cin_i,
`ifdef ALU_SEQ_BYTE_MODE_EN
    input  logic        req_byte_i,
`endif
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [3:0]  alu_s_o,
    output logic        alu_cin_o,
    output logic        alu_m_o,
    input  logic [7:0]  alu_ya_i,
    input  logic [7:0]  alu_yl_i,
    input  logic        alu_cy_i,
    input  logic        alu_ov_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] y_o,
    output logic        cy_o,
    output logic        zf_o,
    output logic        ov_o,
    output logic        sf_o
);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

    localparam logic [3:0] S_SXR = 4'b1101;

    state_t      state_q, state_d;
    logic [7:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]  alu_s_q, alu_s_d;
    logic        alu_cin_q, alu_cin_d, alu_m_q, alu_m_d;
    logic [7:0]  a2_q, a2_d, b2_q, b2_d;
    logic        cin_q, cin_d, hi_first_q, hi_first_d, byte_q, byte_d;
    logic [7:0]  slice1_q, slice1_d;
    logic        ov1_q, ov1_d;
    logic [15:0] y_q, y_d;
    logic        cy_q, cy_d, zf_q, zf_d, ov_q, ov_d, sf_q, sf_d;

    logic        req_byte;
    logic        hi_first;
    logic [7:0]  slice;
    logic [15:0] word;

`ifdef ALU_SEQ_BYTE_MODE_EN
    assign req_byte = req_byte_i;
`else
    assign req_byte = 1'b0;
`endif

    // Only a full-word shift-right needs the high byte first so its LSB can shift into the low byte.
    assign hi_first = (!req_m_i && req_s_i == S_SXR) && !req_byte;
    assign slice    = alu_m_q ? alu_yl_i : alu_ya_i;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_s_d    = alu_s_q;
        alu_cin_d  = alu_cin_q;
        alu_m_d    = alu_m_q;
        a2_d       = a2_q;
        b2_d       = b2_q;
        cin_d      = cin_q;
        hi_first_d = hi_first_q;
        byte_d     = byte_q;
        slice1_d   = slice1_q;
        ov1_d      = ov1_q;
        y_d        = y_q;
        cy_d       = cy_q;
        zf_d       = zf_q;
        ov_d       = ov_q;
        sf_d       = sf_q;
        word       = hi_first_q ? {slice1_q, slice} : {slice, slice1_q};
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    alu_a_d    = hi_first ? req_a_i[15:8] : req_a_i[7:0];
                    alu_b_d    = hi_first ? req_b_i[15:8] : req_b_i[7:0];
                    a2_d       = hi_first ? req_a_i[7:0]  : req_a_i[15:8];
                    b2_d       = hi_first ? req_b_i[7:0]  : req_b_i[15:8];
                    alu_s_d    = req_s_i;
                    alu_m_d    = req_m_i;
                    alu_cin_d  = req_cin_i;
                    cin_d      = req_cin_i;
                    hi_first_d = hi_first;
                    byte_d     = req_byte;
                    state_d    = FIRST;
                end
            end
            FIRST: begin
                slice1_d = slice;
                ov1_d    = alu_ov_i;
                if (byte_q) begin
                    y_d     = {8'h00, slice};
                    cy_d    = !alu_m_q && alu_cy_i;
                    ov_d    = !alu_m_q && alu_ov_i;
                    zf_d    = (slice == 8'h00);
                    sf_d    = slice[7];
                    state_d = DONE;
                end else begin
                    alu_a_d   = a2_q;
                    alu_b_d   = b2_q;
                    // Logic ops reuse the request carry-in; arithmetic chains the first-pass carry.
                    alu_cin_d = alu_m_q ? cin_q : alu_cy_i;
                    state_d   = SECOND;
                end
            end
            SECOND: begin
                y_d     = word;
                cy_d    = !alu_m_q && alu_cy_i;
                ov_d    = !alu_m_q && (hi_first_q ? ov1_q : alu_ov_i);
                zf_d    = (word == 16'h0000);
                sf_d    = word[15];
                state_d = DONE;
            end
            DONE: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_m_q    <= 1'b0;
            a2_q       <= '0;
            b2_q       <= '0;
            cin_q      <= 1'b0;
            hi_first_q <= 1'b0;
            byte_q     <= 1'b0;
            slice1_q   <= '0;
            ov1_q      <= 1'b0;
            y_q        <= '0;
            cy_q       <= 1'b0;
            zf_q       <= 1'b0;
            ov_q       <= 1'b0;
            sf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_s_q    <= alu_s_d;
            alu_cin_q  <= alu_cin_d;
            alu_m_q    <= alu_m_d;
            a2_q       <= a2_d;
            b2_q       <= b2_d;
            cin_q      <= cin_d;
            hi_first_q <= hi_first_d;
            byte_q     <= byte_d;
            slice1_q   <= slice1_d;
            ov1_q      <= ov1_d;
            y_q        <= y_d;
            cy_q       <= cy_d;
            zf_q       <= zf_d;
            ov_q       <= ov_d;
            sf_q       <= sf_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == DONE);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_s_o     = alu_s_q;
    assign alu_cin_o   = alu_cin_q;
    assign alu_m_o     = alu_m_q;
    assign y_o         = y_q;
    assign cy_o        = cy_q;
    assign zf_o        = zf_q;
    assign ov_o        = ov_q;
    assign sf_o        = sf_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer: an 8-bit ALU stand-in, a word-level result model and a response scoreboard.
module tb_alu_word_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_s;
    logic        req_m, req_cin, req_byte;
    logic [7:0]  alu_a, alu_b, alu_ya, alu_yl;
    logic [3:0]  alu_s;
    logic        alu_cin, alu_m, alu_cy, alu_ov;
    logic        rsp_valid, rsp_ready;
    logic [15:0] y;
    logic        cy, zf, ov, sf;

    typedef struct packed {
        logic [15:0] y;
        logic        cy, zf, ov, sf;
    } res_t;

    res_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   rnd_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_word_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_s_i(req_s), .req_m_i(req_m), .req_cin_i(req_cin),
`ifdef ALU_SEQ_BYTE_MODE_EN
        .req_byte_i(req_byte),
`endif
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_s_o(alu_s), .alu_cin_o(alu_cin), .alu_m_o(alu_m),
        .alu_ya_i(alu_ya), .alu_yl_i(alu_yl), .alu_cy_i(alu_cy), .alu_ov_i(alu_ov),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .y_o(y), .cy_o(cy), .zf_o(zf), .ov_o(ov), .sf_o(sf)
    );

    // 8-bit ALU stand-in; the unselected result bus carries junk so a wrong pick shows up.
    logic [8:0] alu_sum;
    always_comb begin
        alu_ya  = 8'h00;
        alu_yl  = 8'h00;
        alu_cy  = 1'b0;
        alu_ov  = 1'b0;
        alu_sum = 9'h000;
        if (alu_m) begin
            case (alu_s)
                4'b1000: alu_yl = alu_a & alu_b;
                4'b1110: alu_yl = alu_a | alu_b;
                4'b0110: alu_yl = alu_a ^ alu_b;
                default: alu_yl = ~alu_a;
            endcase
            alu_ya = ~alu_yl ^ 8'h3C;
        end else begin
            case (alu_s)
                4'b1010: begin
                    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
                    alu_ya  = alu_sum[7:0];
                    alu_cy  = alu_sum[8];
                    alu_ov  = (alu_a[7] == alu_b[7]) && (alu_ya[7] != alu_a[7]);
                end
                4'b0110: begin
                    alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_cin};
                    alu_ya  = alu_sum[7:0];
                    alu_cy  = alu_sum[8];
                    alu_ov  = (alu_a[7] == ~alu_b[7]) && (alu_ya[7] != alu_a[7]);
                end
                4'b1101: begin
                    alu_ya = {alu_cin, alu_a[7:1]};
                    alu_cy = alu_a[0];
                end
                4'b0101: alu_ya = {8{alu_a[7]}};
                default: alu_ya = alu_a;
            endcase
            alu_yl = alu_a ^ alu_b ^ 8'h5A;
        end
    end

    // Expected result straight from word (or byte) arithmetic.
    function automatic res_t model(input logic [15:0] a, b, input logic [3:0] s,
                                   input logic m, cin, byt);
        res_t        r;
        logic [16:0] sum;
        logic [15:0] mask, bb;
        int          w;
        w    = byt ? 8 : 16;
        mask = byt ? 16'h00FF : 16'hFFFF;
        r    = '0;
        if (m) begin
            case (s)
                4'b1000: r.y = a & b & mask;
                4'b1110: r.y = (a | b) & mask;
                4'b0110: r.y = (a ^ b) & mask;
                default: r.y = ~a & mask;
            endcase
        end else begin
            case (s)
                4'b1010, 4'b0110: begin
                    bb   = (s == 4'b0110) ? ~b : b;
                    sum  = {1'b0, a & mask} + {1'b0, bb & mask} + {16'h0, cin};
                    r.y  = sum[15:0] & mask;
                    r.cy = byt ? sum[8] : sum[16];
                    r.ov = (a[w-1] == bb[w-1]) && (r.y[w-1] != a[w-1]);
                end
                4'b1101: begin
                    r.y  = byt ? {8'h00, cin, a[7:1]} : {cin, a[15:1]};
                    r.cy = a[0];
                end
                4'b0101: r.y = {{8{a[15]}}, {8{a[7]}}} & mask;
                default: r.y = a & mask;
            endcase
        end
        r.zf = (r.y == 16'h0000);
        r.sf = r.y[w-1];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Presents a request, waits (bounded) for acceptance and returns 1 time unit after the accept edge.
    task automatic issue(input logic [15:0] a, b, input logic [3:0] s,
                         input logic m, cin, byt, output int t_acc);
        int n;
        req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin; req_byte = byt;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        step();
        t_acc = cyc;
        q.push_back(model(a, b, s, m, cin, byt));
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    // Scoreboard: every cycle a response is presented it must match the oldest accepted op.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                chk("sb_y",  {16'd0, y}, {16'd0, q[0].y});
                chk("sb_cy", {31'd0, cy}, {31'd0, q[0].cy});
                chk("sb_zf", {31'd0, zf}, {31'd0, q[0].zf});
                chk("sb_ov", {31'd0, ov}, {31'd0, q[0].ov});
                chk("sb_sf", {31'd0, sf}, {31'd0, q[0].sf});
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        int t0, t1, n, op;
        logic [3:0] ops_s [7];
        logic       ops_m [7];
        ops_s = '{4'b1010, 4'b0110, 4'b1101, 4'b0101, 4'b1000, 4'b1110, 4'b0110};
        ops_m = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b1,    1'b1};

        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_s = '0;
        req_m = 1'b0; req_cin = 1'b0; req_byte = 1'b0; rsp_ready = 1'b0;
        step(); step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_y", {16'd0, y}, 32'd0);
        chk("rst_flags", {28'd0, cy, zf, ov, sf}, 32'd0);
        chk("rst_alu", {14'd0, alu_a, alu_b, alu_s, alu_cin, alu_m}, 32'd0);
        rst_n = 1'b1;
        step();

        // ADD with carry across the byte boundary; the accept edge counts as the first of three.
        issue(16'h00FF, 16'h0001, 4'b1010, 1'b0, 1'b0, 1'b0, t0);
        chk("t1_p1_a", {24'd0, alu_a}, 32'hFF);
        chk("t1_p1_cin", {31'd0, alu_cin}, 32'd0);
        chk("t1_busy", {31'd0, req_ready}, 32'd0);
        chk("t1_lat1", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("t1_p2_a", {24'd0, alu_a}, 32'h00);
        chk("t1_p2_cin", {31'd0, alu_cin}, 32'd1);
        chk("t1_lat2", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("t1_lat3", {31'd0, rsp_valid}, 32'd1);
        chk("t1_y", {16'd0, y}, 32'h0100);
        chk("t1_flags", {28'd0, cy, zf, ov, sf}, 32'd0);

        // Back-pressure: response held, extra request ignored.
        req_valid = 1'b1; req_a = 16'h1111; req_b = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t5_hold_ready", {31'd0, req_ready}, 32'd0);
            chk("t5_hold_y", {16'd0, y}, 32'h0100);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("t5_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("t5_idle_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("t5_no_queue", {31'd0, rsp_valid}, 32'd0);
        chk("t5_y_kept", {16'd0, y}, 32'h0100);

        // ADD wrap to zero, carry chained into the high pass.
        issue(16'hFFFF, 16'h0001, 4'b1010, 1'b0, 1'b0, 1'b0, t0);
        chk("t2_p1_cin", {31'd0, alu_cin}, 32'd0);
        step();
        chk("t2_p2_cin", {31'd0, alu_cin}, 32'd1);
        chk("t2_p2_a", {24'd0, alu_a}, 32'hFF);
        step();
        chk("t2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2_y", {16'd0, y}, 32'h0000);
        chk("t2_flags", {28'd0, cy, zf, ov, sf}, 32'b1100);
        step();

        // Throughput with the consumer always ready.
        issue(16'h1000, 16'h0234, 4'b1010, 1'b0, 1'b0, 1'b0, t0);
        issue(16'h0001, 16'h0002, 4'b1010, 1'b0, 1'b1, 1'b0, t1);
        chk("throughput", t1 - t0, 32'd4);
        wait_rsp();
        step();

        // Logic AND selects YL on both passes.
        issue(16'hF0F0, 16'h0FF0, 4'b1000, 1'b1, 1'b0, 1'b0, t0);
        chk("t3_p1_m", {31'd0, alu_m}, 32'd1);
        step();
        chk("t3_p2_m", {31'd0, alu_m}, 32'd1);
        step();
        chk("t3_y", {16'd0, y}, 32'h00F0);
        chk("t3_flags", {28'd0, cy, zf, ov, sf}, 32'd0);
        step();

        // Shift right: high byte first, its LSB shifts into the low byte.
        issue(16'h0003, 16'h0000, 4'b1101, 1'b0, 1'b1, 1'b0, t0);
        chk("t4_p1_a", {24'd0, alu_a}, 32'h00);
        chk("t4_p1_cin", {31'd0, alu_cin}, 32'd1);
        step();
        chk("t4_p2_a", {24'd0, alu_a}, 32'h03);
        chk("t4_p2_cin", {31'd0, alu_cin}, 32'd0);
        step();
        chk("t4_y", {16'd0, y}, 32'h8001);
        chk("t4_cy_sf", {30'd0, cy, sf}, 32'b11);
        step();

        // Reset mid-operation discards the op.
        issue(16'hFFFF, 16'h0001, 4'b1010, 1'b0, 1'b0, 1'b0, t0);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_y", {16'd0, y}, 32'd0);
        chk("t6_alu", {14'd0, alu_a, alu_b, alu_s, alu_cin, alu_m}, 32'd0);
        chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
        q.delete();
        step();
        rst_n = 1'b1;
        step();
        issue(16'h1234, 16'h4321, 4'b1010, 1'b0, 1'b0, 1'b0, t0);
        wait_rsp();
        chk("t6_fresh_y", {16'd0, y}, 32'h5555);
        step();

`ifdef ALU_SEQ_BYTE_MODE_EN
        issue(16'h00FF, 16'h0001, 4'b1010, 1'b0, 1'b0, 1'b1, t0);
        chk("byte_lat1", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("byte_lat2", {31'd0, rsp_valid}, 32'd1);
        chk("byte_y", {16'd0, y}, 32'h0000);
        chk("byte_cy_zf", {30'd0, cy, zf}, 32'b11);
        step();
`endif

        // Random traffic with a randomly stalling consumer.
        rnd_mode = 1;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 6);
            req_byte = 1'b0;
`ifdef ALU_SEQ_BYTE_MODE_EN
            req_byte = ($urandom_range(0, 3) == 0);
`endif
            issue(16'($urandom), 16'($urandom), ops_s[op], ops_m[op], 1'($urandom), req_byte, t0);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) step();
        end
        rnd_mode = 0;
        rsp_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
